// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI responder with a local register file, modelled on the
// AD9361 register port. Every SPI pin is oversampled in the clk domain.
// 24-bit frames: W bit, byte count (ignored), address, data.
// Optional build macro: SPI_SLV_PRODUCT_ID_EN (address 10'h037 reads back 8'h0A
// and is write-protected).
module spi_slave_regfile #(
  parameter int          ADDR_W  = 10,
  parameter logic [7:0]  RST_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_enb,
  input  logic              spi_di,
  output logic              spi_do,
  output logic              wr_vld,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_vld,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              frm_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    DONE  = 3'd4
  } state_t;

`ifdef SPI_SLV_PRODUCT_ID_EN
  localparam logic [ADDR_W-1:0] PID_ADDR = ADDR_W'(10'h037);
  localparam logic [7:0]        PID_VAL  = 8'h0A;
`endif

  // Synchroniser bit order: {spi_clk, spi_enb, spi_di}; enb idles high.
  logic [2:0] sync1_q, sync2_q, hist_q;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [14:0]       sr_q, sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rd_sr_q, rd_sr_d;
  logic              do_q, do_d;
  logic              wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              frm_err_q, frm_err_d;
  logic              we_s, mem_we_s;
  logic [7:0]        rd_byte_s;
  logic [15:0]       shift_s;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic              sclk_rise_s, sclk_fall_s, enb_rise_s, enb_fall_s, di_s;
  logic              unused_s;

  logic [7:0] mem_q [2**ADDR_W];

  // Two-stage synchroniser plus history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b010;
      sync2_q <= 3'b010;
      hist_q  <= 3'b010;
    end else begin
      sync1_q <= {spi_clk, spi_enb, spi_di};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign sclk_rise_s = sync2_q[2] & ~hist_q[2];
  assign sclk_fall_s = ~sync2_q[2] & hist_q[2];
  assign enb_rise_s  = sync2_q[1] & ~hist_q[1];
  assign enb_fall_s  = ~sync2_q[1] & hist_q[1];
  assign di_s        = sync2_q[0];

  // After fall 16 shift_s is the command word; after fall 24 its low byte is the data.
  assign shift_s    = {sr_q, di_s};
  assign cmd_addr_s = shift_s[ADDR_W-1:0];
  assign unused_s   = ^shift_s;

  // Register file read port, with the fixed product-id location when enabled.
  always_comb begin
`ifdef SPI_SLV_PRODUCT_ID_EN
    if (cmd_addr_s == PID_ADDR) begin
      rd_byte_s = PID_VAL;
    end else begin
      rd_byte_s = mem_q[cmd_addr_s];
    end
`else
    rd_byte_s = mem_q[cmd_addr_s];
`endif
  end

  // Storage write enable; the product-id location is write-protected when enabled.
  always_comb begin
`ifdef SPI_SLV_PRODUCT_ID_EN
    if (addr_q == PID_ADDR) begin
      mem_we_s = 1'b0;
    end else begin
      mem_we_s = we_s;
    end
`else
    mem_we_s = we_s;
`endif
  end

  // Frame decoder next-state logic; an enb rise always beats a same-clk spi_clk edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    addr_d    = addr_q;
    rd_sr_d   = rd_sr_q;
    do_d      = 1'b0;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_vld_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    frm_err_d = 1'b0;
    we_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enb_fall_s) begin
          state_d = CMD;
          cnt_d   = 5'd0;
          sr_d    = 15'd0;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        if (enb_rise_s) begin
          state_d   = IDLE;
          frm_err_d = 1'b1;
        end else if (sclk_fall_s) begin
          sr_d  = shift_s[14:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            addr_d = cmd_addr_s;
            if (shift_s[15]) begin
              state_d = WDATA;
            end else begin
              state_d   = RDATA;
              rd_addr_d = cmd_addr_s;
              rd_sr_d   = rd_byte_s;
            end
          end else begin
            state_d = CMD;
          end
        end else begin
          state_d = CMD;
        end
      end
      WDATA: begin
        if (enb_rise_s) begin
          state_d   = IDLE;
          frm_err_d = 1'b1;
        end else if (sclk_fall_s) begin
          sr_d  = shift_s[14:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            we_s      = 1'b1;
            wr_vld_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = shift_s[7:0];
            state_d   = DONE;
          end else begin
            state_d = WDATA;
          end
        end else begin
          state_d = WDATA;
        end
      end
      RDATA: begin
        do_d = do_q;
        if (enb_rise_s) begin
          state_d   = IDLE;
          frm_err_d = 1'b1;
          do_d      = 1'b0;
        end else if (sclk_rise_s) begin
          do_d    = rd_sr_q[7];
          rd_sr_d = {rd_sr_q[6:0], 1'b0};
        end else if (sclk_fall_s) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            rd_vld_d = 1'b1;
            state_d  = DONE;
            do_d     = 1'b0;
          end else begin
            state_d = RDATA;
          end
        end else begin
          state_d = RDATA;
        end
      end
      DONE: begin
        if (enb_rise_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      sr_q      <= 15'd0;
      addr_q    <= '0;
      rd_sr_q   <= 8'h00;
      do_q      <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      addr_q    <= addr_d;
      rd_sr_q   <= rd_sr_d;
      do_q      <= do_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      frm_err_q <= frm_err_d;
    end
  end

  // Register file storage; every entry resets to RST_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem_q[i] <= RST_VAL;
      end
    end else if (mem_we_s) begin
      mem_q[addr_q] <= shift_s[7:0];
    end
  end

  assign spi_do  = do_q;
  assign wr_vld  = wr_vld_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_vld  = rd_vld_q;
  assign rd_addr = rd_addr_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed testbench for spi_slave_regfile: bit-banged SPI master at clk/32,
// pulse counters on the strobe outputs, hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_slave_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_enb = 1'b1;
  logic       spi_di = 1'b0;
  logic       spi_do;
  logic       wr_vld;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_vld;
  logic [9:0] rd_addr;
  logic       frm_err;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_pulses  = 0;
  int rd_pulses  = 0;
  int err_pulses = 0;

  spi_slave_regfile #(.ADDR_W(10), .RST_VAL(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .spi_clk (spi_clk),
    .spi_enb (spi_enb),
    .spi_di  (spi_di),
    .spi_do  (spi_do),
    .wr_vld  (wr_vld),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_vld  (rd_vld),
    .rd_addr (rd_addr),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  // Count strobe cycles away from the active edge.
  always @(negedge clk) begin
    if (wr_vld === 1'b1) wr_pulses++;
    if (rd_vld === 1'b1) rd_pulses++;
    if (frm_err === 1'b1) err_pulses++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] wr_frame(input logic [9:0] a, input logic [7:0] d);
    return {1'b1, 2'b00, 3'b000, a, d};
  endfunction

  function automatic logic [23:0] rd_frame(input logic [9:0] a);
    return {1'b0, 2'b00, 3'b000, a, 8'h00};
  endfunction

  // SPI master: di changes mid low phase, do captured just before each pin fall.
  // hold_high leaves the last clock high and enb low (for mid-frame reset).
  task automatic spi_xfer(input logic [23:0] frame, input int nbits, input int gap,
                          input bit hold_high, output logic [7:0] rdata);
    rdata = 8'h00;
    spi_enb = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      spi_di = frame[23-i];
      wait_clk(8);
      spi_clk = 1'b1;
      wait_clk(16);
      if (i >= 16) rdata = {rdata[6:0], spi_do};
      if (hold_high && i == nbits - 1) return;
      spi_clk = 1'b0;
      wait_clk(8);
    end
    spi_enb = 1'b1;
    spi_di  = 1'b0;
    wait_clk(gap);
  endtask

  task automatic test_reset;
    wait_clk(3);
    n_tests++;
    if ({spi_do, wr_vld, wr_addr, wr_data, rd_vld, rd_addr, frm_err} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h expected 0", {spi_do, wr_vld, wr_addr, wr_data, rd_vld, rd_addr, frm_err});
    end
    rst = 1'b0;
    wait_clk(10);
    n_tests++;
    if ({spi_do, wr_vld, wr_addr, wr_data, rd_vld, rd_addr, frm_err} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%h expected 0", {spi_do, wr_vld, wr_addr, wr_data, rd_vld, rd_addr, frm_err});
    end
  endtask

  task automatic test_write_read;
    logic [7:0] rd;
    int w0, r0, e0;
    w0 = wr_pulses; r0 = rd_pulses; e0 = err_pulses;
    spi_xfer(wr_frame(10'h0A5, 8'h3C), 24, 20, 1'b0, rd);
    n_tests++;
    if (wr_pulses - w0 !== 1) begin n_fail++; $display("FAIL wr_vld_count: got %0d expected 1", wr_pulses - w0); end
    n_tests++;
    if (wr_addr !== 10'h0A5) begin n_fail++; $display("FAIL wr_addr: got %h expected 0a5", wr_addr); end
    n_tests++;
    if (wr_data !== 8'h3C) begin n_fail++; $display("FAIL wr_data: got %h expected 3c", wr_data); end
    spi_xfer(rd_frame(10'h0A5), 24, 20, 1'b0, rd);
    n_tests++;
    if (rd !== 8'h3C) begin n_fail++; $display("FAIL read_0a5: got %h expected 3c", rd); end
    n_tests++;
    if (rd_pulses - r0 !== 1) begin n_fail++; $display("FAIL rd_vld_count: got %0d expected 1", rd_pulses - r0); end
    n_tests++;
    if (rd_addr !== 10'h0A5) begin n_fail++; $display("FAIL rd_addr: got %h expected 0a5", rd_addr); end
    n_tests++;
    if (err_pulses - e0 !== 0) begin n_fail++; $display("FAIL no_frm_err: got %0d expected 0", err_pulses - e0); end
    n_tests++;
    if (spi_do !== 1'b0) begin n_fail++; $display("FAIL spi_do_idle: got %b expected 0", spi_do); end
  endtask

  task automatic test_abort;
    logic [7:0] rd;
    int w0, e0;
    spi_xfer(wr_frame(10'h010, 8'hFF), 24, 20, 1'b0, rd);
    w0 = wr_pulses; e0 = err_pulses;
    spi_xfer(wr_frame(10'h010, 8'h00), 10, 20, 1'b0, rd);
    n_tests++;
    if (err_pulses - e0 !== 1) begin n_fail++; $display("FAIL abort_frm_err: got %0d expected 1", err_pulses - e0); end
    n_tests++;
    if (wr_pulses - w0 !== 0) begin n_fail++; $display("FAIL abort_no_wr: got %0d expected 0", wr_pulses - w0); end
    spi_xfer(rd_frame(10'h010), 24, 20, 1'b0, rd);
    n_tests++;
    if (rd !== 8'hFF) begin n_fail++; $display("FAIL abort_read_010: got %h expected ff", rd); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] rd;
    // Bit 20 of a read of 0x0A5 (0x3C) is data bit 4 = 1.
    spi_xfer(rd_frame(10'h0A5), 20, 0, 1'b1, rd);
    n_tests++;
    if (spi_do !== 1'b1) begin n_fail++; $display("FAIL mid_frame_do: got %b expected 1", spi_do); end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({spi_do, wr_vld, wr_addr, wr_data, rd_vld, rd_addr, frm_err} !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_frame_reset: outputs=%h expected 0", {spi_do, wr_vld, wr_addr, wr_data, rd_vld, rd_addr, frm_err});
    end
    spi_clk = 1'b0;
    spi_enb = 1'b1;
    spi_di  = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(10);
    spi_xfer(rd_frame(10'h0A5), 24, 20, 1'b0, rd);
    n_tests++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL post_reset_read: got %h expected 00", rd); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rd;
    int w0;
    w0 = wr_pulses;
    spi_xfer(wr_frame(10'h001, 8'h11), 24, 4, 1'b0, rd);
    spi_xfer(wr_frame(10'h002, 8'h22), 24, 4, 1'b0, rd);
    spi_xfer(wr_frame(10'h3FF, 8'h33), 24, 20, 1'b0, rd);
    n_tests++;
    if (wr_pulses - w0 !== 3) begin n_fail++; $display("FAIL b2b_wr_count: got %0d expected 3", wr_pulses - w0); end
    n_tests++;
    if (wr_addr !== 10'h3FF) begin n_fail++; $display("FAIL b2b_wr_addr: got %h expected 3ff", wr_addr); end
    spi_xfer(rd_frame(10'h001), 24, 4, 1'b0, rd);
    n_tests++;
    if (rd !== 8'h11) begin n_fail++; $display("FAIL b2b_read_001: got %h expected 11", rd); end
    spi_xfer(rd_frame(10'h002), 24, 4, 1'b0, rd);
    n_tests++;
    if (rd !== 8'h22) begin n_fail++; $display("FAIL b2b_read_002: got %h expected 22", rd); end
    spi_xfer(rd_frame(10'h3FF), 24, 20, 1'b0, rd);
    n_tests++;
    if (rd !== 8'h33) begin n_fail++; $display("FAIL b2b_read_3ff: got %h expected 33", rd); end
  endtask

  task automatic test_product_id;
    logic [7:0] rd;
    logic [7:0] exp_rd;
    int w0;
`ifdef SPI_SLV_PRODUCT_ID_EN
    exp_rd = 8'h0A;
`else
    exp_rd = 8'hFF;
`endif
    w0 = wr_pulses;
    spi_xfer(wr_frame(10'h037, 8'hFF), 24, 20, 1'b0, rd);
    n_tests++;
    if (wr_pulses - w0 !== 1) begin n_fail++; $display("FAIL pid_wr_count: got %0d expected 1", wr_pulses - w0); end
    n_tests++;
    if ({wr_addr, wr_data} !== {10'h037, 8'hFF}) begin
      n_fail++;
      $display("FAIL pid_wr_report: got addr %h data %h expected 037 ff", wr_addr, wr_data);
    end
    spi_xfer(rd_frame(10'h037), 24, 20, 1'b0, rd);
    n_tests++;
    if (rd !== exp_rd) begin n_fail++; $display("FAIL pid_read: got %h expected %h", rd, exp_rd); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_abort;
    test_reset_mid_frame;
    test_back_to_back;
    test_product_id;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI responder modelling the AD9361 register port: the far end of the team's SPI master.
- Decodes 24-bit write and read frames into a local 1024x8 register file and drives read data on spi_do.
- Used for loopback verification of the radio driver and as a register-map shadow in FPGA-only builds.
- All SPI pins are oversampled in the clk domain; there is no logic in the spi_clk domain.

Parameters:
ADDR_W, 10, register address width; depth = 2**ADDR_W.
RST_VAL, 8'h00, reset/initial value of every register.

Ports:
clk  input  1  system clock; must be at least 8x spi_clk.
rst  input  1  asynchronous active-high reset.
spi_clk  input  1  SPI clock from master; idles low.
spi_enb  input  1  active-low chip select.
spi_di  input  1  serial data from master, MSB first.
spi_do  output  1  serial read data to master.
wr_vld  output  1  one-clk pulse when a write commits.
wr_addr  output  ADDR_W  address of the committed write; held until next commit.
wr_data  output  8  data of the committed write; held until next commit.
rd_vld  output  1  one-clk pulse when a read frame completes.
rd_addr  output  ADDR_W  address of the last read; held.
frm_err  output  1  one-clk pulse on an aborted frame.

Behaviour:
- Reset (asynchronous, active-high): every output is 0, the FSM is in IDLE, the bit counter is 0, and all registers equal RST_VAL.
- Input sampling: spi_clk, spi_enb and spi_di each pass through a 2-FF synchroniser plus one history flop.
- Edge detection: rise and fall of synchronised spi_clk are one-clk pulses. Bits are sampled on the fall. spi_do changes only on a rise.
- Frame format: bit23 W (1 = write); bits22:21 byte count, ignored (single byte only); bits20:18 ignored; bits17:8 address (low ADDR_W bits used); bits7:0 write data (write frames only).
- FSM states: IDLE, CMD, WDATA, RDATA, DONE.
- IDLE: moves to CMD when synchronised spi_enb falls. The bit counter clears and the shift register clears.
- CMD: each spi_clk fall shifts spi_di into the shift register and increments the counter.
  - After fall 16: if W=1, go to WDATA.
  - If W=0, go to RDATA. rd_addr latches, and the read shift register loads reg[addr] in the same clk.
- WDATA: falls 17..24 shift in data. On fall 24:
  - reg[addr] is updated.
  - wr_addr and wr_data update, and wr_vld pulses in the same clk.
  - FSM goes to DONE.
- RDATA: each spi_clk rise (rises 17..24) drives the current MSB onto spi_do, then shifts left. Fall 24 pulses rd_vld and moves the FSM to DONE.
- spi_do timing and idle level:
  - spi_do is valid no later than 4 clk after the pin-level rise.
  - spi_do is forced to 0 outside RDATA.
  - spi_do returns to 0 on the clk after the FSM leaves RDATA.
- DONE: further spi_clk edges are ignored. spi_enb rise returns the FSM to IDLE.
- Abort: spi_enb rises in CMD/WDATA/RDATA before fall 24.
  - frm_err pulses for 1 clk and the FSM returns to IDLE.
  - No register write and no wr_vld/rd_vld occur.
- spi_enb fall while not in IDLE: ignored, because it cannot occur without an intervening rise.
- Simultaneous events: a spi_clk edge detected in the same clk as a spi_enb rise is discarded; the enb rise wins.
- Back-to-back frames: require spi_enb high for at least 4 clk; the next frame decodes normally.
- Register write/read collision: cannot occur, since writes and read-loads are in different frames.
- Reset mid-frame: immediate return to the reset state. The partial frame is lost and the next full frame decodes normally.

Optional Feature:
SPI_SLV_PRODUCT_ID_EN
- Defined: address 10'h037 is read-only. Reads return 8'h0A regardless of RST_VAL. Writes to it do not change storage, but wr_vld, wr_addr and wr_data still report the attempt.
- Undefined: 10'h037 is an ordinary read/write register.

Test Plan:
- Write 0x0A5<-0x3C (spi_clk = clk/32, matching the driver) -> one wr_vld pulse with wr_addr=0x0A5, wr_data=0x3C. No frm_err.
- Follow with a read of 0x0A5 -> spi_do presents 0,0,1,1,1,1,0,0 on pulses 17..24. Master captures 0x3C; rd_vld pulses once; rd_addr=0x0A5.
- Write 0x010<-0xFF, then raise spi_enb after 10 bits of a second write 0x010<-0x00 -> frm_err pulses once. No wr_vld for the aborted frame; a read of 0x010 returns 0xFF.
- Assert rst during bit 20 of a read -> spi_do=0 and all outputs 0 immediately. A subsequent read of any address returns RST_VAL (0x00).
- Three back-to-back writes with 4-clk enb gaps (0x001<-0x11, 0x002<-0x22, 0x3FF<-0x33), then reads of each -> exactly 3 wr_vld pulses; reads return 0x11, 0x22, 0x33.
- SPI_SLV_PRODUCT_ID_EN defined: write 0x037<-0xFF, then read 0x037.
  - wr_vld pulses with wr_data=0xFF.
  - The read returns 0x0A.
  - Without the macro the read returns 0xFF.
